// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths and operation-select codes used by
// the issue/writeback block and by the ALU selector it drives.
package alu_pkg;

    localparam int XLEN_D = 32;
    localparam int OPW_D  = 4;
    localparam int REGW_D = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLT = 4'd7
    } alu_op_e;

endpackage

// File: rtl/alu_issue_wb_if.sv
// Decode/ALU/writeback bus of the issue block. The block side is the master.
// With ALU_BYPASS_EN defined the bus also carries the operand source indices.
interface alu_issue_wb_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 4,
    parameter int REGW = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [REGW-1:0] in_rd;
`ifdef ALU_BYPASS_EN
    logic [REGW-1:0] in_rs1;
    logic [REGW-1:0] in_rs2;
`endif
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [OPW-1:0]  alu_sel;
    logic [XLEN-1:0] alu_r;
    logic            wb_valid;
    logic            wb_ready;
    logic            wb_we;
    logic [REGW-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        input  in_valid, in_op, in_a, in_b, in_rd,
`ifdef ALU_BYPASS_EN
        input  in_rs1, in_rs2,
`endif
        output in_ready, alu_a, alu_b, alu_sel,
        input  alu_r,
        output wb_valid, wb_we, wb_rd, wb_data,
        input  wb_ready
    );

    modport slave (
        output in_valid, in_op, in_a, in_b, in_rd,
`ifdef ALU_BYPASS_EN
        output in_rs1, in_rs2,
`endif
        input  in_ready, alu_a, alu_b, alu_sel,
        output alu_r,
        input  wb_valid, wb_we, wb_rd, wb_data,
        output wb_ready
    );
endinterface

// File: rtl/alu_pipe_reg.sv
// One valid/ready register slice. Loads whenever it is empty or its content
// leaves this cycle, so a full pipeline of slices runs at one item per cycle.
module alu_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;

    // Load on accept, drop the entry when it leaves without a replacement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_issue_wb.sv
// ALU issue/writeback slice: E register drives the external combinational
// ALU, W register holds the result for the register-file write port.
// Optional feature macro: ALU_BYPASS_EN (W->E operand bypass plus interlock).
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int OPW  = OPW_D,
    parameter int REGW = REGW_D
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_wb_if.master bus,
    output logic [31:0]   retire_cnt
);
    localparam int EW = OPW + 2*XLEN + REGW;
    localparam int WW = REGW + 1 + XLEN;

    logic            e_valid, e_in_ready, w_valid, w_free, ilk;
    logic [EW-1:0]   e_data;
    logic [WW-1:0]   w_in, w_data;
    logic [REGW-1:0] e_rd;
    logic [XLEN-1:0] a_sel, b_sel;

`ifdef ALU_BYPASS_EN
    // Hold decode while the op in E produces a source; it is bypassed from W
    // one cycle later instead.
    assign ilk   = e_valid && (e_rd != '0) &&
                   ((e_rd == bus.in_rs1) || (e_rd == bus.in_rs2));
    assign a_sel = (w_valid && bus.wb_rd != '0 && bus.wb_rd == bus.in_rs1) ? bus.wb_data : bus.in_a;
    assign b_sel = (w_valid && bus.wb_rd != '0 && bus.wb_rd == bus.in_rs2) ? bus.wb_data : bus.in_b;
`else
    assign ilk   = 1'b0;
    assign a_sel = bus.in_a;
    assign b_sel = bus.in_b;
`endif

    assign bus.in_ready = e_in_ready && !ilk;

    alu_pipe_reg #(.W(EW)) u_e (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.in_valid && !ilk),
        .in_ready (e_in_ready),
        .in_data  ({bus.in_op, a_sel, b_sel, bus.in_rd}),
        .out_valid(e_valid),
        .out_ready(w_free),
        .out_data (e_data)
    );

    assign {bus.alu_sel, bus.alu_a, bus.alu_b, e_rd} = e_data;

    // Writes to x0 still complete the handshake but carry no data or enable.
    assign w_in = {e_rd, (e_rd != '0), (e_rd != '0) ? bus.alu_r : {XLEN{1'b0}}};

    alu_pipe_reg #(.W(WW)) u_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (e_valid),
        .in_ready (w_free),
        .in_data  (w_in),
        .out_valid(w_valid),
        .out_ready(bus.wb_ready),
        .out_data (w_data)
    );

    assign bus.wb_valid = w_valid;
    assign {bus.wb_rd, bus.wb_we, bus.wb_data} = w_data;

    // Count completed writeback handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n)                     retire_cnt <= '0;
        else if (w_valid && bus.wb_ready) retire_cnt <= retire_cnt + 32'd1;
    end
endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: drives decode at posedge+1, models the ALU, and a
// negedge monitor scores every accept/retire against an in-order queue.
module tb_alu_issue_wb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] retire_cnt;
    int          cyc = 0;

    alu_issue_wb_if bus ();

    alu_issue_wb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SLT: return {31'b0, ($signed(a) < $signed(b))};
            default: return 32'h0;
        endcase
    endfunction

    // External combinational ALU
    assign bus.alu_r = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    exp_t        push_e;
    int          n_pass = 0;
    int          n_chk  = 0;
    int unsigned n_ret  = 0;
    bit          chk_rdy = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: decides at negedge which handshakes the next posedge completes.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            n_ret = 0;
        end else begin
            // Two ops in flight and no drain means both stages are full.
            if (chk_rdy)
                chk("in_ready", bus.in_ready, !(sbq.size() == 2 && !bus.wb_ready));
            chk("retire_cnt", retire_cnt, n_ret);
            if (sbq.size() == 0)
                chk("wb_valid_idle", bus.wb_valid, 1'b0);
            if (bus.wb_valid && bus.wb_ready && sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("wb_rd", bus.wb_rd, mon_e.rd);
                chk("wb_we", bus.wb_we, mon_e.we);
                chk("wb_data", bus.wb_data, mon_e.data);
                n_ret++;
            end
            if (bus.in_valid && bus.in_ready) begin
                push_e.rd   = bus.in_rd;
                push_e.we   = (bus.in_rd != 0);
                push_e.data = (bus.in_rd != 0) ? alu_f(bus.in_op, bus.in_a, bus.in_b) : 32'h0;
                sbq.push_back(push_e);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1 with request fields set; returns at posedge+1
    // right after the accepting edge.
    task automatic wait_accept();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_op = op;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.in_rd = rd;
        wait_accept();
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) break;
        end
        chk("drain", sbq.size(), 0);
    endtask

    int unsigned base;
    int          cyc0;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_rd    = '0;
`ifdef ALU_BYPASS_EN
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
`endif
        bus.wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_we", bus.wb_we, 1'b0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Single op: one cycle in E, then presented for writeback
        sync();
        issue(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3);
        @(negedge clk);
        chk("single_alu_a", bus.alu_a, 32'hF0F0F0F0);
        chk("single_alu_sel", bus.alu_sel, ALU_AND);
        chk("single_e_stage", bus.wb_valid, 1'b0);
        @(negedge clk);
        chk("single_wb_valid", bus.wb_valid, 1'b1);
        chk("single_wb_rd", bus.wb_rd, 3);
        chk("single_wb_data", bus.wb_data, 32'hF000F000);
        chk("single_wb_we", bus.wb_we, 1'b1);
        @(negedge clk);
        chk("single_retire", retire_cnt, 1);

        // Back-to-back: one accept per cycle
        sync();
        base = n_ret;
        cyc0 = cyc;
        for (int r = 1; r <= 8; r++)
            issue(4'($urandom_range(0, 7)), $urandom, $urandom, 5'(r));
        chk("b2b_cycles", cyc - cyc0, 8);
        drain();
        chk("b2b_retire", retire_cnt, base + 8);

        // x0 write
        sync();
        issue(ALU_ADD, 32'd5, 32'd7, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("x0_wb_valid", bus.wb_valid, 1'b1);
        chk("x0_wb_we", bus.wb_we, 1'b0);
        chk("x0_wb_data", bus.wb_data, 0);
        drain();

        // Backpressure: third op is held off while both stages are full
        sync();
        base = n_ret;
        bus.wb_ready = 1'b0;
        issue(ALU_SUB, 32'd100, 32'd1, 5'd10);
        issue(ALU_XOR, 32'h55, 32'hFF, 5'd11);
        bus.in_op = ALU_OR;
        bus.in_a  = 32'h1234;
        bus.in_b  = 32'h8000;
        bus.in_rd = 5'd12;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 1'b0);
            chk("stall_wb_rd", bus.wb_rd, 10);
            chk("stall_wb_data", bus.wb_data, 32'd99);
            chk("stall_alu_a", bus.alu_a, 32'h55);
        end
        sync();
        bus.wb_ready = 1'b1;
        wait_accept();
        drain();
        chk("stall_retire", retire_cnt, base + 3);

        // Reset with both stages full
        sync();
        bus.wb_ready = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd2, 5'd1);
        issue(ALU_ADD, 32'd3, 32'd4, 5'd2);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("midrst_wb_valid", bus.wb_valid, 1'b0);
        chk("midrst_retire", retire_cnt, 0);
        chk("midrst_in_ready", bus.in_ready, 1'b1);

`ifdef ALU_BYPASS_EN
        // Dependent op stalls one cycle, then takes A from W
        sync();
        issue(ALU_OR, 32'h11, 32'h0, 5'd4);
        chk_rdy = 1'b0;
        bus.in_op  = ALU_ADD;
        bus.in_a   = 32'hDEAD;
        bus.in_b   = 32'h0;
        bus.in_rd  = 5'd0;
        bus.in_rs1 = 5'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("byp_interlock", bus.in_ready, 1'b0);
        sync();
        wait_accept();
        bus.in_rs1 = '0;
        @(negedge clk);
        chk("byp_alu_a", bus.alu_a, 32'h11);
        chk_rdy = 1'b1;
        drain();
`else
        // Same pair without bypass: no stall, operand as presented
        sync();
        cyc0 = cyc;
        issue(ALU_OR, 32'h11, 32'h0, 5'd4);
        issue(ALU_ADD, 32'hDEAD, 32'h1, 5'd5);
        chk("nobyp_cycles", cyc - cyc0, 2);
        @(negedge clk);
        chk("nobyp_alu_a", bus.alu_a, 32'hDEAD);
        drain();
`endif

        // Random traffic with random backpressure
        sync();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_op    = 4'($urandom_range(0, 7));
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            bus.in_rd    = 5'($urandom_range(0, 31));
            bus.wb_ready = ($urandom_range(0, 2) != 0);
            sync();
        end
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("final_retire", retire_cnt, n_ret);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
